// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the seq_scan_ctrl word-to-bit pattern scanner.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } scan_state_t;

  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_scan_ctrl_match4.sv
// Overlapping 4-bit Mealy pattern matcher: the pattern register, 3 bits of history,
// a fill count, and a combinational hit output.
module seq_match4
  import seq_scan_pkg::*;
#(
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic             clr,
  output logic             hit
);

  logic [PAT_W-1:0] pattern;
  logic [2:0]       hist;
  logic [1:0]       fill;

  // hit is Mealy: it depends on the bit being presented this cycle, not a registered copy.
  assign hit = bit_valid && (fill == 2'd3) && ({hist, bit_in} == pattern);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= PATTERN;
      hist    <= '0;
      fill    <= '0;
    end else begin
      if (pat_load) pattern <= pat_value;
      if (clr) begin
        hist <= '0;
        fill <= '0;
      end else if (bit_valid) begin
        hist <= {hist[1:0], bit_in};
        if (fill != 2'd3) fill <= fill + 2'd1;
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit streaming controller around seq_match4. It returns the match count for
// each word and keeps a saturating total. Define SEQ_SCAN_IRQ_EN to add sticky irq/irq_clr.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int               WORD_W  = 8,
  parameter int               CNT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_value,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
`ifdef SEQ_SCAN_IRQ_EN
  output logic              irq,
  input  logic              irq_clr,
`endif
  output logic [15:0]       total_hits
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  scan_state_t       state;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              in_idle;
  logic              hit;

  assign in_idle  = (state == IDLE);
  assign in_ready = in_idle & ~pat_load & ~flush;
  assign cnt_next = cnt + CNT_W'(hit);

  // Pattern load and flush are only honoured in IDLE. A pattern load also clears the history.
  seq_match4 #(.PATTERN(PATTERN)) u_match (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (state == SHIFT),
    .bit_in    (word[idx]),
    .pat_load  (in_idle & pat_load),
    .pat_value (pat_value),
    .clr       (in_idle & (pat_load | flush)),
    .hit       (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      idx        <= '0;
      cnt        <= '0;
      out_count  <= '0;
      out_valid  <= 1'b0;
      total_hits <= '0;
`ifdef SEQ_SCAN_IRQ_EN
      irq        <= 1'b0;
`endif
    end else begin
      if (hit && (total_hits != 16'hFFFF)) total_hits <= total_hits + 16'd1;
`ifdef SEQ_SCAN_IRQ_EN
      if (irq_clr) irq <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            word  <= in_data;
            cnt   <= '0;
            idx   <= IDX_W'(WORD_W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt_next;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            out_count <= cnt_next;
            out_valid <= 1'b1;
            state     <= REPORT;
`ifdef SEQ_SCAN_IRQ_EN
            // Placed after the clear so a simultaneous set wins.
            if (cnt_next != '0) irq <= 1'b1;
`endif
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: a table of words plus hand-written sequences for
// backpressure and reset. Expected counts go into a scoreboard queue when a word is accepted.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              pat_load;
  logic [3:0]        pat_value;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [15:0]       total_hits;
`ifdef SEQ_SCAN_IRQ_EN
  logic              irq;
  logic              irq_clr;
`endif

  seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .PATTERN(4'b1011)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .pat_load   (pat_load),
    .pat_value  (pat_value),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
`ifdef SEQ_SCAN_IRQ_EN
    .irq        (irq),
    .irq_clr    (irq_clr),
`endif
    .total_hits (total_hits)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int tot_exp  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic       do_flush;
    logic       do_load;
    logic [3:0] pat;
    logic [7:0] data;
    int         exp_count;
  } vec_t;

  vec_t vecs[8];

  // All tasks start and end just after a rising edge.
  task automatic idle_ctrl(input logic do_flush, input logic do_load, input logic [3:0] pat);
    if (do_flush || do_load) begin
      flush     = do_flush;
      pat_load  = do_load;
      pat_value = pat;
      @(negedge clk);
      check("in_ready_during_ctrl", in_ready, 0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      pat_load = 1'b0;
    end
  endtask

  task automatic start_word(input logic [7:0] data, input int exp_count);
    in_valid = 1'b1;
    in_data  = data;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    exp_q.push_back(exp_count);
    tot_exp += exp_count;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_word(input int hold, input int lat);
    int n;
    int exp_count;
    n = 0;
    @(negedge clk);
    check("in_ready_busy", in_ready, 0);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("report_latency", n, lat);
    exp_count = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check("out_valid_seen", out_valid, 1);
    check("out_count", out_count, exp_count);
    check("total_hits", total_hits, tot_exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_count", out_count, exp_count);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'b0000, 8'b1011_0110, 2};  // overlapping matches
    vecs[1] = '{1'b1, 1'b0, 4'b0000, 8'h05,        0};
    vecs[2] = '{1'b0, 1'b0, 4'b0000, 8'h80,        1};  // match spans the word boundary
    vecs[3] = '{1'b1, 1'b0, 4'b0000, 8'h05,        0};
    vecs[4] = '{1'b1, 1'b0, 4'b0000, 8'h80,        0};  // flush breaks the spanning match
    vecs[5] = '{1'b0, 1'b1, 4'b0000, 8'h00,        5};
    vecs[6] = '{1'b0, 1'b1, 4'b1011, 8'b1011_1011, 2};
    vecs[7] = '{1'b1, 1'b1, 4'b0110, 8'b0110_1101, 2};  // load and flush together

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    pat_load  = 1'b0;
    pat_value = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
`ifdef SEQ_SCAN_IRQ_EN
    irq_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_total_hits", total_hits, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SEQ_SCAN_IRQ_EN
    check("rst_irq", irq, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      idle_ctrl(vecs[v].do_flush, vecs[v].do_load, vecs[v].pat);
      start_word(vecs[v].data, vecs[v].exp_count);
      finish_word(0, WORD_W);
    end

    // Backpressure: a second word waits on in_valid while the report is held.
    idle_ctrl(1'b1, 1'b0, 4'b0000);
    start_word(8'b0110_0000, 1);
    in_valid = 1'b1;
    in_data  = 8'h00;
    finish_word(5, WORD_W);
    start_word(8'h00, 0);
    finish_word(0, WORD_W);

    // Reset in the middle of SHIFT after loading an all-zero pattern.
    idle_ctrl(1'b0, 1'b1, 4'b0000);
    start_word(8'h00, 5);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_count", out_count, 0);
    check("midrst_total_hits", total_hits, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    tot_exp = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_word(8'b1011_0000, 1);
    finish_word(0, WORD_W);
`ifdef SEQ_SCAN_IRQ_EN
    @(negedge clk);
    check("irq_set", irq, 1);
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    @(negedge clk);
    check("irq_cleared", irq, 0);
    @(posedge clk);
    #1;
`endif

    // The default pattern is back. pat_load and flush during SHIFT must have no effect.
    start_word(8'b1011_0110, 2);
    repeat (2) @(posedge clk);
    #1;
    pat_load  = 1'b1;
    pat_value = 4'b0000;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    flush    = 1'b0;
    finish_word(0, WORD_W - 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
